// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D memory arbiter: FSM states, grant codes
// and the fixed request attributes used for I-cache line fetches.
// Round-robin tie breaking is enabled by defining MEM_ARB_RR_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

    localparam logic [1:0] I_SIZE = 2'b10;
    localparam logic [3:0] I_SEL  = 4'b1111;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational two-way picker. Returns the grant code of the winner among
// the I and D requests. In round-robin mode a tie goes to the side that was
// not served last (last_d = 1 means D was served last); otherwise I wins.
import mem_arb_pkg::*;

module arb_pick (
    input  logic       req_i,
    input  logic       req_d,
    input  logic       last_d,
    input  logic       rr_mode,
    output logic [1:0] winner
);

    // Pick the winner; a tie only goes to D when rotating and I was served last
    always_comb begin
        winner = GRANT_NONE;
        if (req_i && req_d) begin
            winner = (rr_mode && !last_d) ? GRANT_D : GRANT_I;
        end else if (req_i) begin
            winner = GRANT_I;
        end else if (req_d) begin
            winner = GRANT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between the I-cache and D-cache for a single shared AXI port.
// A grant is held until mem_ready, then passes straight to the other side
// if it is waiting. Read data bypasses this block entirely.
// Define MEM_ARB_RR_EN for round-robin ties; default is fixed I priority.
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_a,
    input  logic              i_access,
    output logic              i_ready,
    input  logic [ADDR_W-1:0] d_a,
    input  logic              d_access,
    input  logic              d_write,
    input  logic [1:0]        d_size,
    input  logic [3:0]        d_sel,
    input  logic [DATA_W-1:0] d_st_data,
    output logic              d_ready,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_access,
    output logic              mem_write,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_sel,
    output logic [DATA_W-1:0] mem_st_data,
    input  logic              mem_ready,
    output logic [1:0]        grant,
    output logic              busy
);

    arb_state_t state;
    arb_state_t state_next;
    logic [1:0] pick;
    logic       last_d;
    logic       rr_mode;

`ifdef MEM_ARB_RR_EN
    assign rr_mode = 1'b1;

    // Remember which side completed last so the next tie goes to the other
    always_ff @(posedge clk) begin
        if (rst) begin
            last_d <= 1'b1;
        end else if (mem_ready && (state != IDLE)) begin
            last_d <= (state == GNT_D);
        end
    end
`else
    assign rr_mode = 1'b0;
    assign last_d  = 1'b1;
`endif

    arb_pick u_pick (
        .req_i   (i_access),
        .req_d   (d_access),
        .last_d  (last_d),
        .rr_mode (rr_mode),
        .winner  (pick)
    );

    // State register; reset drops any grant in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: arbitrate from IDLE, hand over directly on completion
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pick == GRANT_I) begin
                    state_next = GNT_I;
                end else if (pick == GRANT_D) begin
                    state_next = GNT_D;
                end
            end
            GNT_I: begin
                if (mem_ready) begin
                    state_next = d_access ? GNT_D : IDLE;
                end
            end
            GNT_D: begin
                if (mem_ready) begin
                    state_next = i_access ? GNT_I : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output mux; everything is forced quiet while reset is asserted
    always_comb begin
        mem_a       = '0;
        mem_access  = 1'b0;
        mem_write   = 1'b0;
        mem_size    = 2'b00;
        mem_sel     = 4'b0000;
        mem_st_data = '0;
        i_ready     = 1'b0;
        d_ready     = 1'b0;
        grant       = GRANT_NONE;
        if (!rst) begin
            case (state)
                GNT_I: begin
                    mem_a      = i_a;
                    mem_access = 1'b1;
                    mem_size   = I_SIZE;
                    mem_sel    = I_SEL;
                    i_ready    = mem_ready;
                    grant      = GRANT_I;
                end
                GNT_D: begin
                    mem_a       = d_a;
                    mem_access  = 1'b1;
                    mem_write   = d_write;
                    mem_size    = d_size;
                    mem_sel     = d_sel;
                    mem_st_data = d_st_data;
                    d_ready     = mem_ready;
                    grant       = GRANT_D;
                end
                default: begin
                    grant = GRANT_NONE;
                end
            endcase
        end
        busy = (grant != GRANT_NONE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A transaction-level model tracks who
// owns the memory port and predicts every output each cycle; directed steps
// cover the documented scenarios, followed by a randomized run.
// Follows MEM_ARB_RR_EN for the tie-breaking rule it expects.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic [AW-1:0] i_a;
    logic          i_access;
    logic          i_ready;
    logic [AW-1:0] d_a;
    logic          d_access;
    logic          d_write;
    logic [1:0]    d_size;
    logic [3:0]    d_sel;
    logic [DW-1:0] d_st_data;
    logic          d_ready;
    logic [AW-1:0] mem_a;
    logic          mem_access;
    logic          mem_write;
    logic [1:0]    mem_size;
    logic [3:0]    mem_sel;
    logic [DW-1:0] mem_st_data;
    logic          mem_ready;
    logic [1:0]    grant;
    logic          busy;

    int total = 0;
    int bad   = 0;

    // model: owner 0 = nobody, 1 = I-cache, 2 = D-cache
    int owner   = 0;
    bit last_d  = 1'b1;
    bit rr_mode;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_a         (i_a),
        .i_access    (i_access),
        .i_ready     (i_ready),
        .d_a         (d_a),
        .d_access    (d_access),
        .d_write     (d_write),
        .d_size      (d_size),
        .d_sel       (d_sel),
        .d_st_data   (d_st_data),
        .d_ready     (d_ready),
        .mem_a       (mem_a),
        .mem_access  (mem_access),
        .mem_write   (mem_write),
        .mem_size    (mem_size),
        .mem_sel     (mem_sel),
        .mem_st_data (mem_st_data),
        .mem_ready   (mem_ready),
        .grant       (grant),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Compare every DUT output against what the ownership model predicts
    task automatic check_output(input string tag);
        logic [71:0] exp_bus;
        logic [71:0] obs_bus;
        logic [1:0]  exp_grant;
        logic        exp_iready;
        logic        exp_dready;
        int          eff;
        eff = rst ? 0 : owner;
        exp_bus    = '0;
        exp_grant  = 2'b00;
        exp_iready = 1'b0;
        exp_dready = 1'b0;
        if (eff == 1) begin
            exp_bus    = {i_a, 1'b1, 1'b0, 2'b10, 4'hF, 32'h0};
            exp_grant  = 2'b01;
            exp_iready = mem_ready;
        end else if (eff == 2) begin
            exp_bus    = {d_a, 1'b1, d_write, d_size, d_sel, d_st_data};
            exp_grant  = 2'b10;
            exp_dready = mem_ready;
        end
        obs_bus = {mem_a, mem_access, mem_write, mem_size, mem_sel, mem_st_data};
        total++;
        assert (grant === exp_grant) else begin
            bad++;
            $error("[TB] FAIL %s grant observed=%h expected=%h", tag, grant, exp_grant);
        end
        total++;
        assert (busy === (exp_grant != 2'b00)) else begin
            bad++;
            $error("[TB] FAIL %s busy observed=%b expected=%b", tag, busy, exp_grant != 2'b00);
        end
        total++;
        assert (obs_bus === exp_bus) else begin
            bad++;
            $error("[TB] FAIL %s mem_bus observed=%h expected=%h", tag, obs_bus, exp_bus);
        end
        total++;
        assert (i_ready === exp_iready) else begin
            bad++;
            $error("[TB] FAIL %s i_ready observed=%b expected=%b", tag, i_ready, exp_iready);
        end
        total++;
        assert (d_ready === exp_dready) else begin
            bad++;
            $error("[TB] FAIL %s d_ready observed=%b expected=%b", tag, d_ready, exp_dready);
        end
    endtask

    // Advance the ownership model by one clock using the inputs held this cycle
    task automatic model_step();
        int other;
        bit other_req;
        if (rst) begin
            owner  = 0;
            last_d = 1'b1;
        end else if (owner == 0) begin
            if (i_access && d_access) begin
                owner = (rr_mode && !last_d) ? 2 : 1;
            end else if (i_access) begin
                owner = 1;
            end else if (d_access) begin
                owner = 2;
            end
        end else if (mem_ready) begin
            last_d    = (owner == 2);
            other     = 3 - owner;
            other_req = (other == 1) ? i_access : d_access;
            owner     = other_req ? other : 0;
        end
    endtask

    // One clock: check after inputs settle, then cross the rising edge
    task automatic apply_stimulus(input string tag);
        #1;
        check_output(tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
`ifdef MEM_ARB_RR_EN
        rr_mode = 1'b1;
`else
        rr_mode = 1'b0;
`endif
        rst = 1'b1; i_a = '0; i_access = 1'b0; d_a = '0; d_access = 1'b0;
        d_write = 1'b0; d_size = 2'b00; d_sel = 4'h0; d_st_data = '0; mem_ready = 1'b0;
        @(negedge clk);

        // reset state
        apply_stimulus("reset0");
        apply_stimulus("reset1");
        rst = 1'b0;

        // single I fetch, mem_ready in cycle 6, i_access dropped early
        i_a = 32'h0040_1230; i_access = 1'b1;
        apply_stimulus("i_c1");
        i_access = 1'b0;
        for (int c = 2; c <= 5; c++) apply_stimulus("i_wait");
        mem_ready = 1'b1;
        apply_stimulus("i_done");
        mem_ready = 1'b0;
        apply_stimulus("i_idle");

        // D store passthrough
        d_a = 32'h1FAF_0000; d_access = 1'b1; d_write = 1'b1; d_size = 2'b10;
        d_sel = 4'h3; d_st_data = 32'hDEAD_BEEF;
        apply_stimulus("d_c1");
        d_access = 1'b0;
        apply_stimulus("d_wait");
        mem_ready = 1'b1;
        apply_stimulus("d_done");
        mem_ready = 1'b0;
        apply_stimulus("d_idle");

        // simultaneous requests from reset, then continuous contention
        rst = 1'b1;
        apply_stimulus("tie_rst");
        rst = 1'b0;
        i_access = 1'b1; d_access = 1'b1; d_write = 1'b0;
        apply_stimulus("tie_arb");
        for (int t = 0; t < 6; t++) begin
            logic [1:0] want;
            want = (t % 2 == 0) ? 2'b01 : 2'b10;
            apply_stimulus("tie_hold");
            mem_ready = 1'b1;
            #1;
            total++;
            assert (grant === want) else begin
                bad++;
                $error("[TB] FAIL tie_order observed=%h expected=%h", grant, want);
            end
            apply_stimulus("tie_done");
            mem_ready = 1'b0;
        end
        i_access = 1'b0; d_access = 1'b0;
        apply_stimulus("tie_drain");
        mem_ready = 1'b1;
        apply_stimulus("tie_drain_done");
        mem_ready = 1'b0;
        apply_stimulus("tie_idle");

        // reset while D waits, then a stray mem_ready
        rst = 1'b1;
        apply_stimulus("rd_rst");
        rst = 1'b0;
        d_access = 1'b1;
        apply_stimulus("rd_req");
        d_access = 1'b0;
        apply_stimulus("rd_wait");
        rst = 1'b1;
        apply_stimulus("rd_abort");
        rst = 1'b0;
        mem_ready = 1'b1;
        apply_stimulus("rd_stray");
        mem_ready = 1'b0;
        apply_stimulus("rd_idle");

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 59) == 0);
            i_access  = ($urandom_range(0, 2) != 0);
            d_access  = ($urandom_range(0, 2) != 0);
            mem_ready = ($urandom_range(0, 2) == 0);
            i_a       = $urandom;
            d_a       = $urandom;
            d_write   = 1'($urandom);
            d_size    = 2'($urandom);
            d_sel     = 4'($urandom);
            d_st_data = $urandom;
            apply_stimulus("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
